tube_scroller: RTL

Sequential renderer for the scrolling tube column. It consumes VGA pixel coordinates and drives local coordinates into a 16x16 tube sprite ROM (row registered on clock, column selected combinationally, per-pixel mask). It composites the returned sprite RGB over a background stream, 2-cycle pipelined. It also owns the tube's horizontal scroll position and gap placement, updated once per frame. It sits between the VGA timing generator and the final RGB output mux.

---
 rtl/tube_scroller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/tube_scroller.sv
// Scrolling tube column: per-frame scroll/gap state plus a 2-stage
// hit-test and sprite-over-background composite pipeline.
module tube_scroller #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int TUBE_W      = 16,
    parameter int GAP_H       = 120,
    parameter int SPEED       = 2,
    parameter int GAP_DEFAULT = 180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        frame_tick,
    input  logic [10:0] gap_in,
    input  logic [10:0] px,
    input  logic [10:0] py,
    input  logic        pix_valid,
    input  logic [7:0]  bg_r,
    input  logic [7:0]  bg_g,
    input  logic [7:0]  bg_b,
    output logic [10:0] spr_x,
    output logic [10:0] spr_y,
    input  logic [7:0]  spr_r,
    input  logic [7:0]  spr_g,
    input  logic [7:0]  spr_b,
    input  logic        spr_mask,
    output logic [7:0]  oR,
    output logic [7:0]  oG,
    output logic [7:0]  oB,
    output logic        o_valid,
    output logic [10:0] tube_x,
    output logic [10:0] gap_y,
    output logic        wrap
);

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [10:0] RELOAD   = 11'(SCREEN_W);
    localparam logic [10:0] STEP     = 11'(SPEED);
    localparam logic [10:0] GAP_MAX  = 11'(SCREEN_H - GAP_H);
    localparam logic [10:0] GAP_INIT = 11'(GAP_DEFAULT);
    localparam logic [11:0] TUBE_W12 = 12'(TUBE_W);
    localparam logic [11:0] GAP_H12  = 12'(GAP_H);

    state_t      state;
    logic [10:0] gap_clamped;

    logic [11:0] tube_end;
    logic [11:0] gap_end;
    logic        in_col;
    logic        in_gap;
    logic        hit;
    logic [3:0]  local_x;

    logic        hit_d;
    logic        valid_d;
    logic [7:0]  bg_r_d;
    logic [7:0]  bg_g_d;
    logic [7:0]  bg_b_d;
    logic        show_spr;

    assign gap_clamped = (gap_in > GAP_MAX) ? GAP_MAX : gap_in;

    // State is the registered enable, so a tick coinciding with a
    // falling enable still scrolls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= HOLD;
            tube_x <= RELOAD;
            gap_y  <= GAP_INIT;
            wrap   <= 1'b0;
        end else begin
            wrap  <= 1'b0;
            state <= enable ? RUN : HOLD;
            if (state == RUN && frame_tick) begin
                if (tube_x >= STEP) begin
                    tube_x <= tube_x - STEP;
                end else begin
                    tube_x <= RELOAD;
                    gap_y  <= gap_clamped;
                    wrap   <= 1'b1;
                end
            end
        end
    end

    // 12-bit edges keep tube_x = SCREEN_W from overflowing.
    assign tube_end = {1'b0, tube_x} + TUBE_W12;
    assign gap_end  = {1'b0, gap_y} + GAP_H12;
    assign in_col   = (px >= tube_x) && ({1'b0, px} < tube_end);
    assign in_gap   = (py >= gap_y) && ({1'b0, py} < gap_end);
    assign hit      = pix_valid && in_col && !in_gap;
    assign local_x  = px[3:0] - tube_x[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_d   <= 1'b0;
            valid_d <= 1'b0;
            bg_r_d  <= 8'd0;
            bg_g_d  <= 8'd0;
            bg_b_d  <= 8'd0;
            spr_x   <= 11'd0;
            spr_y   <= 11'd0;
        end else begin
            hit_d   <= hit;
            valid_d <= pix_valid;
            bg_r_d  <= bg_r;
            bg_g_d  <= bg_g;
            bg_b_d  <= bg_b;
            spr_x   <= hit ? {7'd0, local_x} : 11'd0;
            spr_y   <= {7'd0, py[3:0]};
        end
    end

    assign show_spr = hit_d && spr_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            oR      <= 8'd0;
            oG      <= 8'd0;
            oB      <= 8'd0;
        end else begin
            o_valid <= valid_d;
            if (!valid_d) begin
                oR <= 8'd0;
                oG <= 8'd0;
                oB <= 8'd0;
            end else if (show_spr) begin
                oR <= spr_r;
                oG <= spr_g;
                oB <= spr_b;
            end else begin
                oR <= bg_r_d;
                oG <= bg_g_d;
                oB <= bg_b_d;
            end
        end
    end

endmodule
